// File: rtl/dar_pkg.sv
// dar_pkg: shared definitions for the register-file BIST initiator.
//   state_t         - march sequencer states
//   DAR_AW/DW/NREGS - default geometry of the register file under test
//   FAILW           - width of the mismatch counter (holds 0..2*NREGS)
package dar_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR1  = 3'd1,
    RD1  = 3'd2,
    WR2  = 3'd3,
    RD2  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int DAR_AW    = 2;
  localparam int DAR_DW    = 8;
  localparam int DAR_NREGS = 4;
  localparam int FAILW     = 4;

endpackage

// File: rtl/dar_bist_if.sv
// dar_bist_if: register-file access port driven by the BIST initiator.
//   w_en  - write enable        (master -> slave)
//   r_en  - read enable         (master -> slave)
//   addr  - register address    (master -> slave)
//   wdata - register data in    (master -> slave)
//   rdata - register data out   (slave -> master), combinational, gated by r_en
interface dar_bist_if
  import dar_pkg::*;
#(
  parameter int AW = DAR_AW,
  parameter int DW = DAR_DW
);

  logic          w_en;
  logic          r_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output w_en, output r_en, output addr, output wdata, input rdata);
  modport slave  (input w_en, input r_en, input addr, input wdata, output rdata);

endinterface

// File: rtl/dar_bist.sv
// dar_bist: built-in self-test initiator for a small register file.
// A start pulse (accepted only in IDLE) latches seed S and runs a march:
// write S+a to every address, read back and compare, then the same with
// ~(S+a). A one-cycle done pulse reports pass / fail_count / first_fail_addr.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, seed     - run request and base pattern
//   busy, done      - running flag, result-valid pulse
//   pass            - high when the last run had zero mismatches
//   fail_count      - number of mismatching reads
//   first_fail_addr - address of the first mismatch (0 if none)
//   rf              - register-file port (w_en, r_en, addr, wdata, rdata)
module dar_bist
  import dar_pkg::*;
#(
  parameter int NREGS = DAR_NREGS,
  parameter int AW    = DAR_AW,
  parameter int DW    = DAR_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [FAILW-1:0] fail_count,
  output logic [AW-1:0]    first_fail_addr,
  dar_bist_if.master       rf
);

  localparam logic [AW-1:0]    A_LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0]    A_ZERO = AW'(0);
  localparam logic [AW-1:0]    A_ONE  = AW'(1);
  localparam logic [DW-1:0]    D_ZERO = DW'(0);
  localparam logic [FAILW-1:0] F_ZERO = FAILW'(0);
  localparam logic [FAILW-1:0] F_ONE  = FAILW'(1);

  // March pattern: base plus address (wrapping), optionally inverted.
  function automatic logic [DW-1:0] pattern_f(input logic [DW-1:0] base,
                                              input logic [AW-1:0] idx,
                                              input logic          inv);
    logic [DW-1:0] sum_v;
    sum_v = base + DW'(idx);
    if (inv) begin
      return ~sum_v;
    end else begin
      return sum_v;
    end
  endfunction

  state_t           state_r, state_s;
  logic [AW-1:0]    a_r, a_s;
  logic [DW-1:0]    seed_r;
  logic [FAILW-1:0] fail_count_r, fail_next_s;
  logic [AW-1:0]    first_fail_r;
  logic             pass_r;

  logic             at_last_s;
  logic             accept_s;
  logic             w_en_s, r_en_s;
  logic [AW-1:0]    addr_s;
  logic [DW-1:0]    wdata_s, expect_s;
  logic             check_s, mismatch_s;
  logic             run_end_s;

  assign at_last_s = (a_r == A_LAST);
  assign accept_s  = (state_r == IDLE) && start;

  // Next-state and address-counter sequencing.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    case (state_r)
      IDLE: begin
        a_s = A_ZERO;
        if (start) begin
          state_s = WR1;
        end else begin
          state_s = IDLE;
        end
      end
      WR1, RD1, WR2, RD2: begin
        // a wraps naturally from NREGS-1 to 0 because NREGS == 2**AW
        a_s = a_r + A_ONE;
        if (at_last_s) begin
          case (state_r)
            WR1:     state_s = RD1;
            RD1:     state_s = WR2;
            WR2:     state_s = RD2;
            RD2:     state_s = DONE;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        a_s     = A_ZERO;
        state_s = IDLE;
      end
      default: begin
        a_s     = A_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // Register-file port decode and expected read data, from registered state only.
  always_comb begin
    w_en_s   = 1'b0;
    r_en_s   = 1'b0;
    addr_s   = A_ZERO;
    wdata_s  = D_ZERO;
    expect_s = D_ZERO;
    check_s  = 1'b0;
    case (state_r)
      WR1: begin
        w_en_s  = 1'b1;
        addr_s  = a_r;
        wdata_s = pattern_f(seed_r, a_r, 1'b0);
      end
      RD1: begin
        r_en_s   = 1'b1;
        addr_s   = a_r;
        expect_s = pattern_f(seed_r, a_r, 1'b0);
        check_s  = 1'b1;
      end
      WR2: begin
        w_en_s  = 1'b1;
        addr_s  = a_r;
        wdata_s = pattern_f(seed_r, a_r, 1'b1);
      end
      RD2: begin
        r_en_s   = 1'b1;
        addr_s   = a_r;
        expect_s = pattern_f(seed_r, a_r, 1'b1);
        check_s  = 1'b1;
      end
      default: begin
        w_en_s   = 1'b0;
        r_en_s   = 1'b0;
        addr_s   = A_ZERO;
        wdata_s  = D_ZERO;
        expect_s = D_ZERO;
        check_s  = 1'b0;
      end
    endcase
  end

  // Comparator and the fail count as it will stand after this edge.
  always_comb begin
    mismatch_s = check_s && (rf.rdata != expect_s);
    if (mismatch_s) begin
      fail_next_s = fail_count_r + F_ONE;
    end else begin
      fail_next_s = fail_count_r;
    end
  end

  // The last RD2 compare lands on the same edge that enters DONE.
  assign run_end_s = (state_r == RD2) && at_last_s;

  // Sequencer state and address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= A_ZERO;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
    end
  end

  // Seed latch and result registers; start clears the previous results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r       <= D_ZERO;
      fail_count_r <= F_ZERO;
      first_fail_r <= A_ZERO;
      pass_r       <= 1'b0;
    end else if (accept_s) begin
      seed_r       <= seed;
      fail_count_r <= F_ZERO;
      first_fail_r <= A_ZERO;
      pass_r       <= 1'b0;
    end else begin
      fail_count_r <= fail_next_s;
      if (mismatch_s && (fail_count_r == F_ZERO)) begin
        first_fail_r <= a_r;
      end
      if (run_end_s) begin
        pass_r <= (fail_next_s == F_ZERO);
      end
    end
  end

  assign busy            = (state_r == WR1) || (state_r == RD1) ||
                           (state_r == WR2) || (state_r == RD2);
  assign done            = (state_r == DONE);
  assign pass            = pass_r;
  assign fail_count      = fail_count_r;
  assign first_fail_addr = first_fail_r;

  assign rf.w_en  = w_en_s;
  assign rf.r_en  = r_en_s;
  assign rf.addr  = addr_s;
  assign rf.wdata = wdata_s;

endmodule

// File: tb/tb_dar_bist.sv
// tb_dar_bist: scoreboard bench for dar_bist with a behavioural 4x8
// register file that can inject read faults.
module tb_dar_bist;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [1:0] first_fail_addr;

  dar_bist_if #(.AW(2), .DW(8)) rf ();

  dar_bist #(.NREGS(4), .AW(2), .DW(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr),
    .rf              (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fault: 0 none, 1 bit0 forced low at addr 2, 2 all reads stuck at 0x00
  logic [1:0] fault;
  logic [7:0] mem [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else if (rf.w_en) begin
      mem[rf.addr] <= rf.wdata;
    end
  end

  assign rf.rdata = !rf.r_en                     ? 8'h00 :
                    (fault == 2'd2)              ? 8'h00 :
                    (fault == 2'd1 && rf.addr == 2'd2) ? (mem[rf.addr] & 8'hFE) :
                    mem[rf.addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       pass;
    logic [3:0] fc;
    logic [1:0] ffa;
    int         dcyc;
  } res_t;

  res_t       res_q[$];
  logic [9:0] wr_q[$];
  int         stray_done = 0;
  int         excl_err = 0;

  // Write monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (!rst && rf.w_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {54'd0, rf.addr, rf.wdata}, 64'd0);
      end else begin
        logic [9:0] e;
        e = wr_q.pop_front();
        chk("write", {54'd0, rf.addr, rf.wdata}, {54'd0, e});
      end
    end
  end

  // Result monitor: on done, compare results and the done cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (res_q.size() == 0) begin
        stray_done++;
      end else begin
        res_t e;
        e = res_q.pop_front();
        chk("pass", 64'(pass), 64'(e.pass));
        chk("fail_count", 64'(fail_count), 64'(e.fc));
        chk("first_fail_addr", 64'(first_fail_addr), 64'(e.ffa));
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
      end
    end
  end

  // Port rules: never both enables; idle port is all zero when not busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf.w_en && rf.r_en) excl_err++;
      if (!busy && (rf.w_en || rf.r_en || rf.addr != 2'd0 || rf.wdata != 8'h00)) excl_err++;
    end
  end

  typedef struct packed {
    logic [7:0]  seed;
    logic [1:0]  fault;
    logic        exp_pass;
    logic [3:0]  exp_fc;
    logic [1:0]  exp_ffa;
    logic [63:0] exp_wr;   // byte i = i-th write (WR1 a=0..3, then WR2 a=0..3)
  } vec_t;

  localparam logic [63:0] WR_10 = 64'hECEDEEEF_13121110;
  localparam logic [63:0] WR_FE = 64'hFEFF0001_0100FFFE;

  task automatic push_writes(input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      wr_q.push_back({2'(i % 4), b});
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && res_q.size() != 0; i++) @(negedge clk);
    chk(name, 64'(res_q.size()), 64'd0);
    res_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {42'd0, busy, done, pass, fail_count, first_fail_addr,
               rf.w_en, rf.r_en, rf.addr, rf.wdata}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    @(negedge clk);
    fault = v.fault;
    seed  = v.seed;
    start = 1'b1;
    push_writes(v.exp_wr);
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = cyc;
    res_q.push_back('{pass: v.exp_pass, fc: v.exp_fc, ffa: v.exp_ffa, dcyc: acc + 16});
    @(negedge clk);
    chk("busy_c1", 64'(busy), 64'd1);
    repeat (15) @(negedge clk);
    chk("busy_c16", 64'(busy), 64'd1);
    @(negedge clk);
    chk("busy_c17", 64'(busy), 64'd0);
    drain("run_timeout");
  endtask

  vec_t vecs[4];

  initial begin
    int acc;
    int dsnap;
    vecs[0] = '{seed: 8'h10, fault: 2'd0, exp_pass: 1'b1, exp_fc: 4'd0, exp_ffa: 2'd0, exp_wr: WR_10};
    vecs[1] = '{seed: 8'hFE, fault: 2'd0, exp_pass: 1'b1, exp_fc: 4'd0, exp_ffa: 2'd0, exp_wr: WR_FE};
    vecs[2] = '{seed: 8'h10, fault: 2'd1, exp_pass: 1'b0, exp_fc: 4'd1, exp_ffa: 2'd2, exp_wr: WR_10};
    vecs[3] = '{seed: 8'h10, fault: 2'd2, exp_pass: 1'b0, exp_fc: 4'd8, exp_ffa: 2'd0, exp_wr: WR_10};

    rst   = 1'b1;
    start = 1'b0;
    seed  = 8'h00;
    fault = 2'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("idle_state");

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // start held high: stuck-at run, then healthy run accepted at edge 18
    @(negedge clk);
    seed  = 8'h10;
    fault = 2'd2;
    start = 1'b1;
    push_writes(WR_10);
    push_writes(WR_10);
    @(posedge clk);
    #1;
    acc = cyc;
    res_q.push_back('{pass: 1'b0, fc: 4'd8, ffa: 2'd0, dcyc: acc + 16});
    res_q.push_back('{pass: 1'b1, fc: 4'd0, ffa: 2'd0, dcyc: acc + 34});
    repeat (17) @(negedge clk);
    chk("b2b_busy_done", 64'(busy), 64'd0);
    fault = 2'd0;
    @(negedge clk);
    chk("b2b_idle_hold", {59'd0, busy, pass, fail_count}, {59'd0, 1'b0, 1'b0, 4'd8});
    @(negedge clk);
    chk("b2b_cleared", {59'd0, busy, pass, fail_count}, {59'd0, 1'b1, 1'b0, 4'd0});
    start = 1'b0;
    drain("b2b_timeout");

    // reset pulsed in cycle 7 (RD1): everything zero, no done
    @(negedge clk);
    seed  = 8'h10;
    start = 1'b1;
    push_writes(WR_10);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    dsnap = stray_done;
    repeat (25) @(negedge clk);
    chk("no_done_after_reset", 64'(stray_done - dsnap), 64'd0);
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    chk("write_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("port_rules", 64'(excl_err), 64'd0);
    chk("stray_done", 64'(stray_done), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
